// File: rtl/policy_mem.sv
// policy_mem: DEPTH x DATA_W policy table with byte-strobed writes,
// one-cycle reads with write-first bypass and a hardware clear sweep.
module policy_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                clr_req,
  output logic                busy,
  output logic                drop
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q;
  logic                drop_q;
  logic                busy_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                wr_fire;
  logic                rd_fire;
  logic                reject;
  logic [DATA_W-1:0]   wr_merged;
  logic [DATA_W-1:0]   rd_word;

  // A clear request in RUN takes priority over same-cycle traffic.
  assign accept  = (state_q == RUN) && !clr_req;
  assign wr_fire = accept && wr_en;
  assign rd_fire = accept && rd_req;
  assign reject  = (wr_en || rd_req) && !accept;

  always_comb begin
    wr_merged = mem_q[wr_addr];
    for (int b = 0; b < NB; b++) begin
      if (wr_strb[b]) begin
        wr_merged[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem_q[rd_addr];
    if (wr_fire && (wr_addr == rd_addr)) begin
      rd_word = wr_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CLEAR;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      rd_valid_q <= rd_fire;
      rd_data_q  <= rd_fire ? rd_word : '0;
      drop_q     <= reject;
      unique case (state_q)
        CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (clr_req) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= CLEAR;
          idx_q   <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Array carries no reset; the sweep defines its contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_q[idx_q] <= '0;
      end else if (wr_fire) begin
        mem_q[wr_addr] <= wr_merged;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign drop     = drop_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_policy_mem.sv
// tb_policy_mem: directed vectors for the 32x16 and 64x64 policy tables.
module tb_policy_mem;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit / 16-entry instance
  logic        rst;
  logic        we, re, clr;
  logic [3:0]  wa, ra, ws;
  logic [31:0] wd;
  logic [31:0] rdata;
  logic        rvalid, busy, drop;

  // 64-bit / 64-entry instance
  logic        rst6;
  logic        we6, re6, clr6;
  logic [5:0]  wa6, ra6;
  logic [7:0]  ws6;
  logic [63:0] wd6;
  logic [63:0] rdata6;
  logic        rvalid6, busy6, drop6;

  policy_mem #(.DATA_W(32), .ADDR_W(4)) u_dut32 (
    .clk(clk), .rst(rst),
    .wr_en(we), .wr_addr(wa), .wr_data(wd), .wr_strb(ws),
    .rd_req(re), .rd_addr(ra), .rd_data(rdata), .rd_valid(rvalid),
    .clr_req(clr), .busy(busy), .drop(drop)
  );

  policy_mem #(.DATA_W(64), .ADDR_W(6)) u_dut64 (
    .clk(clk), .rst(rst6),
    .wr_en(we6), .wr_addr(wa6), .wr_data(wd6), .wr_strb(ws6),
    .rd_req(re6), .rd_addr(ra6), .rd_data(rdata6), .rd_valid(rvalid6),
    .clr_req(clr6), .busy(busy6), .drop(drop6)
  );

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        re;
    logic [3:0]  ra;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic we_, input logic [3:0] wa_,
                     input logic [31:0] wd_, input logic [3:0] ws_,
                     input logic re_, input logic [3:0] ra_,
                     input logic ev_, input logic [31:0] ed_);
    vec_t v;
    v.we = we_; v.wa = wa_; v.wd = wd_; v.ws = ws_;
    v.re = re_; v.ra = ra_; v.ev = ev_; v.ed = ed_;
    tbl.push_back(v);
  endtask

  task automatic drive32(input logic we_, input logic [3:0] wa_,
                         input logic [31:0] wd_, input logic [3:0] ws_,
                         input logic re_, input logic [3:0] ra_,
                         input logic clr_);
    @(negedge clk);
    we = we_; wa = wa_; wd = wd_; ws = ws_;
    re = re_; ra = ra_; clr = clr_;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic drive64(input logic we_, input logic [5:0] wa_,
                         input logic [63:0] wd_, input logic [7:0] ws_,
                         input logic re_, input logic [5:0] ra_,
                         input logic clr_);
    @(negedge clk);
    we6 = we_; wa6 = wa_; wd6 = wd_; ws6 = ws_;
    re6 = re_; ra6 = ra_; clr6 = clr_;
    @(posedge clk);
    #1;
    we6 = 1'b0; re6 = 1'b0; clr6 = 1'b0;
  endtask

  int cnt, cnt6, g;

  initial begin
    rst = 1'b1; rst6 = 1'b1;
    we = 0; re = 0; clr = 0; wa = 0; ra = 0; ws = 0; wd = 0;
    we6 = 0; re6 = 0; clr6 = 0; wa6 = 0; ra6 = 0; ws6 = 0; wd6 = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1);
    check("reset rd_valid", rvalid, 0);
    check("reset rd_data", rdata, 0);
    check("reset drop", drop, 0);
    check("reset busy64", busy6, 1);

    // Release both and count busy cycles sampled mid-cycle
    @(negedge clk);
    rst = 1'b0; rst6 = 1'b0;
    cnt = 0; cnt6 = 0; g = 0;
    while ((busy || busy6) && g < 200) begin
      if (busy) cnt++;
      if (busy6) cnt6++;
      g++;
      @(negedge clk);
    end
    check("init busy cycles 32", cnt, 16);
    check("init busy cycles 64", cnt6, 64);

    for (int i = 0; i < 16; i++) add(0, 0, 0, 0, 1, 4'(i), 1, 32'h0);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0);
    add(1, 3, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 32'h0);
    add(1, 3, 32'h11223344, 4'b0101, 0, 0, 0, 32'h0);
    add(0, 0, 0, 0, 1, 3, 1, 32'hDE22BE44);
    add(1, 7, 32'h12345678, 4'b1111, 0, 0, 0, 32'h0);
    add(1, 7, 32'hCAFEF00D, 4'b1100, 1, 7, 1, 32'hCAFE5678);
    add(0, 0, 0, 0, 1, 7, 1, 32'hCAFE5678);
    add(1, 7, 32'hFFFFFFFF, 4'b0000, 1, 7, 1, 32'hCAFE5678);
    add(1, 5, 32'hAAAA5555, 4'b1111, 1, 3, 1, 32'hDE22BE44);
    add(0, 0, 0, 0, 1, 5, 1, 32'hAAAA5555);
    for (int i = 0; i < 8; i++)
      add(1, 4'(i), 32'(i) * 32'h01010101, 4'b1111, 0, 0, 0, 32'h0);
    for (int i = 0; i < 8; i++)
      add(0, 0, 0, 0, 1, 4'(i), 1, 32'(i) * 32'h01010101);
    add(0, 0, 0, 0, 0, 0, 0, 32'h0);

    foreach (tbl[i]) begin
      drive32(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ws,
              tbl[i].re, tbl[i].ra, 1'b0);
      check($sformatf("vec%0d rd_valid", i), rvalid, tbl[i].ev);
      check($sformatf("vec%0d rd_data", i), rdata, tbl[i].ed);
      check($sformatf("vec%0d drop", i), drop, 0);
      check($sformatf("vec%0d busy", i), busy, 0);
    end

    // Asynchronous reset between edges while a read result is showing
    drive32(0, 0, 0, 0, 1, 1, 0);
    check("pre-reset rd_valid", rvalid, 1);
    check("pre-reset rd_data", rdata, 32'h01010101);
    #2 rst = 1'b1;
    #1;
    check("async rst rd_valid", rvalid, 0);
    check("async rst rd_data", rdata, 0);
    check("async rst busy", busy, 1);
    check("async rst drop", drop, 0);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0; g = 0;
    while (busy && g < 200) begin
      cnt++; g++;
      @(negedge clk);
    end
    check("re-sweep busy cycles", cnt, 16);
    drive32(0, 0, 0, 0, 1, 1, 0);
    check("post-sweep rd_valid", rvalid, 1);
    check("post-sweep addr1", rdata, 0);

    // Clear request with a colliding write, then a read during the sweep
    drive32(1, 2, 32'h02020202, 4'b1111, 0, 0, 0);
    cnt = 0;
    drive32(1, 2, 32'hA5A5A5A5, 4'b1111, 0, 0, 1);
    if (busy) cnt++;
    check("clr drop", drop, 1);
    check("clr busy", busy, 1);
    check("clr rd_valid", rvalid, 0);
    drive32(0, 0, 0, 0, 1, 2, 0);
    if (busy) cnt++;
    check("busy read drop", drop, 1);
    check("busy read rd_valid", rvalid, 0);
    check("busy read rd_data", rdata, 0);
    drive32(0, 0, 0, 0, 0, 0, 0);
    if (busy) cnt++;
    check("drop single pulse", drop, 0);
    g = 0;
    while (busy && g < 200) begin
      @(posedge clk);
      #1;
      if (busy) cnt++;
      g++;
    end
    check("clr busy cycles", cnt, 16);
    drive32(0, 0, 0, 0, 1, 2, 0);
    check("after clr rd_valid", rvalid, 1);
    check("after clr addr2", rdata, 0);
    drive32(0, 0, 0, 0, 1, 5, 0);
    check("after clr addr5", rdata, 0);

    // 64-bit table: 8-lane strobe merge, bypass and clear length
    drive64(1, 63, 64'h0123456789ABCDEF, 8'hFF, 0, 0, 0);
    drive64(1, 63, 64'hFFEEDDCCBBAA9988, 8'b10100101, 0, 0, 0);
    drive64(0, 0, 0, 0, 1, 63, 0);
    check("w64 rd_valid", rvalid6, 1);
    check("w64 merge", rdata6, 64'hFF23DD6789AACD88);
    drive64(1, 10, 64'hAAAAAAAABBBBBBBB, 8'hF0, 1, 10, 0);
    check("w64 bypass", rdata6, 64'hAAAAAAAA00000000);
    drive64(0, 0, 0, 0, 1, 0, 0);
    check("w64 addr0", rdata6, 0);
    cnt6 = 0;
    drive64(0, 0, 0, 0, 0, 0, 1);
    if (busy6) cnt6++;
    check("w64 clr drop", drop6, 0);
    g = 0;
    while (busy6 && g < 300) begin
      @(posedge clk);
      #1;
      if (busy6) cnt6++;
      g++;
    end
    check("w64 clr busy cycles", cnt6, 64);
    drive64(0, 0, 0, 0, 1, 63, 0);
    check("w64 cleared rd_valid", rvalid6, 1);
    check("w64 cleared addr63", rdata6, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/policy_mem.md
# policy_mem

Parametrised policy-table memory: a single-clock, DEPTH×DATA_W register array with one byte-strobed write port and one request/valid read port. Unlike the earlier fixed 16×32 table, reads and writes run concurrently with write-first bypass, and a hardware clear sequencer zeroes the array after reset or on request. It sits between the AXI-lite register front-end, which writes policy entries, and the policy checker, which reads them.

## Interface
- DATA_W, 32: entry width in bits; must be a multiple of 8.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W entries.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request, sampled each edge.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_strb  in  DATA_W/8  byte enables; bit b covers wr_data[8b+7:8b].
- rd_req  in  1  read request, sampled each edge.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data; zero whenever rd_valid is low.
- rd_valid  out  1  one-cycle pulse marking rd_data valid.
- clr_req  in  1  start a clear sweep.
- busy  out  1  high while the clear sweep runs.
- drop  out  1  one-cycle pulse: a wr_en/rd_req was rejected the previous cycle.

## Operation
- FSM with two states, CLEAR and RUN. Async reset forces CLEAR with sweep index 0.
- CLEAR: writes zero to entry[idx] each cycle, then idx+1. After idx = DEPTH-1 is written, the FSM goes to RUN. busy = (state == CLEAR), registered.
- CLEAR ignores clr_req; it does not restart the sweep. Any wr_en or rd_req sampled in CLEAR is discarded, pulses drop next cycle and leaves rd_valid low.
- RUN write: when wr_en=1, for each b with wr_strb[b]=1, byte b of entry[wr_addr] gets byte b of wr_data. Other bytes are unchanged. wr_strb = 0 is accepted and changes nothing.
- RUN read: when rd_req=1, rd_data gets entry[rd_addr] and rd_valid=1 on the next cycle. Without rd_req, both are 0 next cycle.
- Same-cycle rd_req and wr_en at the same address: rd_data returns the merged post-write value (write-first bypass). At different addresses, both complete independently.
- clr_req=1 in RUN: enters CLEAR at the next edge with idx=0. A wr_en or rd_req in that same cycle is rejected, drop pulses, and no write occurs.
- drop is asserted for at most one cycle per rejecting edge, regardless of how many requests were rejected.
- Reset mid-sweep or mid-read: rd_valid, rd_data and drop clear immediately, and the sweep restarts at idx 0.
- Addresses are always in range because DEPTH = 2**ADDR_W. idx wraps only by leaving CLEAR.

## Timing
- Reset values (asynchronous): rd_data=0, rd_valid=0, drop=0, busy=1, idx=0. Array contents are undefined until the sweep completes.
- Sweep timing after rst deasserts:
  - Entry k is zeroed at the k-th rising edge (k = 0..DEPTH-1).
  - busy is low after edge DEPTH-1, so it is high for exactly DEPTH cycles.
  - The first request accepted is the one sampled at edge DEPTH.
- A clr_req sampled at edge n gives busy high from n to n+DEPTH and RUN at edge n+DEPTH+1.
- Read latency is 1 cycle: request sampled at edge n, rd_valid and rd_data valid after edge n, low again after edge n+1 unless re-requested.
- Back-to-back reads, one per cycle, are supported at full throughput.
- Write latency is 1 edge. A read at the same address on the following cycle returns the new value.
- drop asserts the cycle after the rejected request.

## Test plan
- Reset with DATA_W=32, ADDR_W=4: busy high for 16 cycles. Then reading all 16 addresses returns 0x00000000 with rd_valid pulsing once per request.
- Write 0xDEADBEEF to addr 3 with strb=4'b1111, then write 0x11223344 to addr 3 with strb=4'b0101. A read of addr 3 returns 0xDE22BE44.
- Same cycle: write 0xCAFEF00D with strb=4'b1100 to addr 7 (previously 0x12345678) while reading addr 7. Next cycle, rd_data = 0xCAFE5678.
- Pulse clr_req while also asserting wr_en to addr 2 with 0xA5A5A5A5:
  - drop pulses and busy is high for 16 cycles.
  - rd_req during busy gives drop pulses and no rd_valid.
  - Afterwards, addr 2 reads 0.
- Run 8 back-to-back reads of addrs 0..7 after writing data = addr×0x01010101. Expect 8 consecutive rd_valid cycles with the matching data.
- Assert rst asynchronously mid-read, between clock edges: rd_valid and rd_data drop to 0 immediately and busy rises. Also repeat the tests with DATA_W=64, ADDR_W=6: busy lasts 64 cycles and an 8-bit strobe merge is checked.
